// File: rtl/clk_period_monitor_if.sv
// clk_period_monitor_if: signal bundle between a slow-clock source and its period monitor
//   sig_in       monitored slow square wave (source -> monitor)
//   edge_tick    one-cycle pulse per synchronized rising edge
//   period       last measured full period in clk cycles
//   period_valid one-cycle pulse when period updates
//   in_range     last period within tolerance
//   lost         no rising edge for TIMEOUT cycles
//   clr/lost_seen sticky-flag clear and flag, only with CLK_PERIOD_MONITOR_STICKY_EN
interface clk_period_monitor_if;
    logic        sig_in;
    logic        edge_tick;
    logic [31:0] period;
    logic        period_valid;
    logic        in_range;
    logic        lost;
`ifdef CLK_PERIOD_MONITOR_STICKY_EN
    logic        clr;
    logic        lost_seen;
    modport master(output sig_in, clr, input edge_tick, period, period_valid, in_range, lost, lost_seen);
    modport slave(input sig_in, clr, output edge_tick, period, period_valid, in_range, lost, lost_seen);
`else
    modport master(output sig_in, input edge_tick, period, period_valid, in_range, lost);
    modport slave(input sig_in, output edge_tick, period, period_valid, in_range, lost);
`endif
endinterface

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures each full period of a slow clock in clk cycles and flags range/loss
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  clk_period_monitor_if.slave: sig_in in; edge_tick, period, period_valid, in_range, lost out
//   Optional sticky loss/out-of-range flag (bus.clr, bus.lost_seen) with CLK_PERIOD_MONITOR_STICKY_EN
module clk_period_monitor #(
    parameter logic [31:0] EXP_HALF = 32'd50000000,
    parameter logic [31:0] TOL      = 32'd1000,
    parameter logic [31:0] TIMEOUT  = 32'd200000000
) (
    input logic clk,
    input logic rst,
    clk_period_monitor_if.slave bus
);
    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, LOST} state_t;
    localparam logic [31:0] NOM = EXP_HALF << 1;
    localparam logic [31:0] LO  = (NOM < TOL) ? 32'd0 : NOM - TOL;
    localparam logic [31:0] HI  = NOM + TOL;
    state_t      state, state_n;
    logic        s1, s2, s3;
    logic [31:0] cnt;
    logic        rise, report, to_lost;
    assign rise = s2 & ~s3;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= WAIT_FIRST;
        else state <= state_n;
    // A rise always beats a simultaneous timeout. A rise while lost serves as the
    // reference edge, so the first full period after recovery is reported at the next rise.
    always_comb begin
        state_n = state;
        report  = 1'b0;
        to_lost = 1'b0;
        if (rise) begin
            state_n = MEASURE;
            report  = (state == MEASURE);
        end else if (cnt == TIMEOUT && state != LOST) begin
            state_n = LOST;
            to_lost = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {s1, s2, s3}     <= 3'b000;
            cnt              <= 32'd0;
            bus.edge_tick    <= 1'b0;
            bus.period       <= 32'd0;
            bus.period_valid <= 1'b0;
            bus.in_range     <= 1'b0;
            bus.lost         <= 1'b0;
        end else begin
            {s1, s2, s3}     <= {bus.sig_in, s1, s2};
            cnt              <= rise ? 32'd1 : (&cnt ? cnt : cnt + 32'd1);
            bus.edge_tick    <= rise;
            bus.period_valid <= report;
            if (report) begin
                bus.period   <= cnt;
                bus.in_range <= (cnt >= LO) && (cnt <= HI);
            end
            if (to_lost) begin
                bus.lost     <= 1'b1;
                bus.in_range <= 1'b0;
            end else if (rise) bus.lost <= 1'b0;
        end
`ifdef CLK_PERIOD_MONITOR_STICKY_EN
    // Set has priority over clr.
    always_ff @(posedge clk or posedge rst)
        if (rst) bus.lost_seen <= 1'b0;
        else bus.lost_seen <= (bus.lost || (bus.period_valid && !bus.in_range)) ? 1'b1 :
                              bus.clr ? 1'b0 : bus.lost_seen;
`endif
endmodule
